// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst initiator for a single-port SRAM wrapper with
// registered read data. Write bursts stream wd_* straight onto the SRAM
// port. Read bursts are issued against a credit (inflight + fifo_cnt) so
// every returned word always has a FIFO slot, whatever rd_ready does.
// Optional: define SRAM_CTRL_PERF_CNT_EN to add 32-bit saturating
// perf_wr_cnt / perf_rd_cnt / perf_stall_cnt outputs.
module sram_burst_ctrl #(
  parameter int DATA_BIT     = 128,
  parameter int DEPTH        = 128,
  parameter int ADDR_BIT     = $clog2(DEPTH),
  parameter int LEN_BIT      = ADDR_BIT,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_BIT-1:0] cmd_addr,
  input  logic [LEN_BIT-1:0]  cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_BIT-1:0] wd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                done,
  output logic                busy,
  output logic [ADDR_BIT-1:0] sram_addr,
  output logic                sram_wen,
  output logic                sram_ren,
  output logic [DATA_BIT-1:0] sram_wdata,
  input  logic [DATA_BIT-1:0] sram_rdata
`ifdef SRAM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         perf_wr_cnt,
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  // Counter width covers the worst-case inflight + fifo_cnt sum.
  localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_BIT-1:0]       cur_addr;
  logic [LEN_BIT:0]          beats;
  logic [READ_LATENCY-1:0]   vld_pipe;
  logic [DATA_BIT-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt, inflight;
  logic                      credit_ok, push, pop, last_beat, drain_last;
  logic                      cmd_fire, done_q, done_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight = set bits of the latency valid pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end

  assign credit_ok  = (inflight + fifo_cnt) < CNT_W'(FIFO_DEPTH);
  assign push       = vld_pipe[READ_LATENCY-1];
  assign rd_valid   = (fifo_cnt != '0);
  assign rd_data    = fifo_mem[rd_ptr];
  assign pop        = rd_valid & rd_ready;
  assign last_beat  = (beats == (LEN_BIT+1)'(1));
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign drain_last = (inflight == '0) && (fifo_cnt == CNT_W'(1)) && pop;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign sram_addr  = cur_addr;
  assign sram_wdata = sram_wen ? wd_data : '0;

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_we ? WRITE : READ;
      end
      WRITE: begin
        wd_ready = 1'b1;
        sram_wen = wd_valid;
        if (wd_valid && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        sram_ren = credit_ok;
        if (credit_ok && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Burst address/beat tracking: latch on accept, step on every access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      beats    <= '0;
    end else if (cmd_fire) begin
      cur_addr <= cmd_addr;
      beats    <= {1'b0, cmd_len} + (LEN_BIT+1)'(1);
    end else if (sram_wen || sram_ren) begin
      cur_addr <= cur_addr + 1'b1;
      beats    <= beats - 1'b1;
    end
  end

  // Read latency valid pipe; the last stage marks sram_rdata as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= sram_ren;
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Return FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Return FIFO storage; contents only matter while counted valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= sram_rdata;
  end

`ifdef SRAM_CTRL_PERF_CNT_EN
  logic stall;
  assign stall = ((state_q == READ) && !credit_ok) ||
                 ((state_q == DRAIN) && rd_valid && !rd_ready);

  // Saturating activity/stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wr_cnt    <= '0;
      perf_rd_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (sram_wen && perf_wr_cnt != '1)    perf_wr_cnt    <= perf_wr_cnt + 1'b1;
      if (sram_ren && perf_rd_cnt != '1)    perf_rd_cnt    <= perf_rd_cnt + 1'b1;
      if (stall && perf_stall_cnt != '1)    perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
